// File: rtl/alu_seq_ctrl.sv
// Operation sequencer and display scheduler for the ALU/decoder datapath.
// Latches operands on a start request, captures ALU results and multiplexes two BCD digits.
module alu_seq_ctrl #(
   parameter int HOLD_CYCLES = 1024,
   parameter int SCAN_DIV    = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] num_a_in,
   input  logic [2:0] num_b_in,
   input  logic [1:0] sel_op_in,
   input  logic       mode_in,
   input  logic       start_in,
   input  logic [5:0] alu_res_in,
   output logic [2:0] alu_a_out,
   output logic [2:0] alu_b_out,
   output logic [1:0] alu_op_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       disp_on_out,
   output logic       digit_sel_out,
   output logic [3:0] digit_val_out
);

   localparam int HW = $clog2(HOLD_CYCLES);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, SHOW} state_t;

   state_t        state_reg, state_next;
   logic          sync1_reg, sync2_reg, sync3_reg;
   logic          start_pulse;
   logic [2:0]    a_reg, a_next;
   logic [2:0]    b_reg, b_next;
   logic [1:0]    op_reg, op_next;
   logic          mode_reg, mode_next;
   logic [5:0]    res_reg, res_next;
   logic [HW-1:0] hold_reg, hold_next;
   logic          done_reg, done_next;
   logic [SW-1:0] scan_reg;
   logic          sel_reg;
   logic [3:0]    ones, tens;

   // start_in is asynchronous: two flops for metastability, a third for edge detection
   assign start_pulse = sync2_reg & ~sync3_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         sync3_reg <= 1'b0;
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         op_reg    <= '0;
         mode_reg  <= 1'b0;
         res_reg   <= '0;
         hold_reg  <= '0;
         done_reg  <= 1'b0;
      end else begin
         sync1_reg <= start_in;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         op_reg    <= op_next;
         mode_reg  <= mode_next;
         res_reg   <= res_next;
         hold_reg  <= hold_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      op_next    = op_reg;
      mode_next  = mode_reg;
      res_next   = res_reg;
      hold_next  = hold_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: if (start_pulse) state_next = LOAD;
         LOAD: begin
            a_next     = num_a_in;
            b_next     = num_b_in;
            mode_next  = mode_in;
            op_next    = mode_in ? 2'd0 : sel_op_in;
            state_next = EXEC;
         end
         EXEC: begin
            res_next   = alu_res_in;
            hold_next  = '0;
            state_next = SHOW;
         end
         SHOW: begin
            if (hold_reg == HOLD_LAST) begin
               // auto mode walks ops 0..3 before returning to IDLE
               if (mode_reg && op_reg != 2'd3) begin
                  op_next    = op_reg + 2'd1;
                  state_next = EXEC;
               end else begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               hold_next = hold_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_reg <= '0;
         sel_reg  <= 1'b0;
      end else if (scan_reg == SCAN_LAST) begin
         scan_reg <= '0;
         sel_reg  <= ~sel_reg;
      end else begin
         scan_reg <= scan_reg + 1'b1;
      end
   end

   assign ones = 4'(res_reg % 6'd10);
   assign tens = 4'(res_reg / 6'd10);

   assign alu_a_out     = a_reg;
   assign alu_b_out     = b_reg;
   assign alu_op_out    = op_reg;
   assign busy_out      = (state_reg != IDLE);
   assign done_out      = done_reg;
   assign disp_on_out   = (state_reg == SHOW);
   assign digit_sel_out = sel_reg;
   assign digit_val_out = disp_on_out ? (sel_reg ? tens : ones) : 4'd0;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus pushes expected results, a monitor checks each SHOW and done.
module tb_alu_seq_ctrl;

   localparam int HOLD = 8;
   localparam int SCAN = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] num_a_in = '0, num_b_in = '0;
   logic [1:0] sel_op_in = '0;
   logic       mode_in = 1'b0, start_in = 1'b0;
   logic [5:0] alu_res_in;
   logic [2:0] alu_a_out, alu_b_out;
   logic [1:0] alu_op_out;
   logic       busy_out, done_out, disp_on_out, digit_sel_out;
   logic [3:0] digit_val_out;
   logic       force63 = 1'b0;

   typedef struct {
      int a;
      int b;
      int op;
      int res;
   } exp_t;

   exp_t exp_q[$];
   int   len_q[$];
   int   tests = 0, fails = 0;
   int   done_cnt = 0, done_exp = 0;

   always #5 clk = ~clk;

   function automatic int ref_alu(input int a, input int b, input int op);
      case (op)
         0: return a + b;
         1: return (a > b) ? a - b : b - a;
         2: return a * b;
         default: return a & b;
      endcase
   endfunction

   assign alu_res_in = force63 ? 6'd63
                     : 6'(ref_alu(int'(alu_a_out), int'(alu_b_out), int'(alu_op_out)));

   alu_seq_ctrl #(.HOLD_CYCLES(HOLD), .SCAN_DIV(SCAN)) dut (
      .clk(clk), .rst_n(rst_n),
      .num_a_in(num_a_in), .num_b_in(num_b_in), .sel_op_in(sel_op_in),
      .mode_in(mode_in), .start_in(start_in), .alu_res_in(alu_res_in),
      .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_op_out(alu_op_out),
      .busy_out(busy_out), .done_out(done_out), .disp_on_out(disp_on_out),
      .digit_sel_out(digit_sel_out), .digit_val_out(digit_val_out)
   );

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops one expectation per SHOW period, one busy length per done
   exp_t cur;
   bit   prev_disp = 0, sel_seen = 0, last_sel = 0;
   int   show_len = 0, busy_len = 0, sel_run = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_disp = 0; sel_seen = 0; last_sel = 0;
         show_len = 0; busy_len = 0; sel_run = 0;
      end else begin
         if (disp_on_out && !prev_disp) begin
            if (exp_q.size() == 0) begin
               check("unexpected_show", 1, 0);
               cur = '{a: 0, b: 0, op: 0, res: 0};
            end else begin
               cur = exp_q.pop_front();
               check("alu_a", int'(alu_a_out), cur.a);
               check("alu_b", int'(alu_b_out), cur.b);
               check("alu_op", int'(alu_op_out), cur.op);
            end
            show_len = 0;
         end
         if (disp_on_out) begin
            show_len++;
            check("digit_val", int'(digit_val_out),
                  digit_sel_out ? cur.res / 10 : cur.res % 10);
         end else begin
            check("digit_off", int'(digit_val_out), 0);
            if (prev_disp) check("show_len", show_len, HOLD);
         end
         prev_disp = disp_on_out;

         if (busy_out) busy_len++;
         if (done_out) begin
            done_cnt++;
            check("busy_at_done", int'(busy_out), 0);
            if (len_q.size() == 0) check("unexpected_done", 1, 0);
            else check("busy_len", busy_len, len_q.pop_front());
            busy_len = 0;
         end

         if (digit_sel_out != last_sel) begin
            if (sel_seen) check("scan_period", sel_run, SCAN);
            sel_seen = 1;
            sel_run = 1;
            last_sel = digit_sel_out;
         end else begin
            sel_run++;
         end
      end
   end

   task automatic push_exp(input int a, input int b, input int sel, input int mode, input bit f63);
      if (mode != 0) begin
         for (int op = 0; op < 4; op++)
            exp_q.push_back('{a: a, b: b, op: op, res: f63 ? 63 : ref_alu(a, b, op)});
      end else begin
         exp_q.push_back('{a: a, b: b, op: sel, res: f63 ? 63 : ref_alu(a, b, sel)});
      end
   endtask

   task automatic wait_busy(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy_out) begin seen = 1; break; end
      end
      check("busy_seen", int'(seen), 1);
   endtask

   task automatic wait_disp(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (disp_on_out) begin seen = 1; break; end
      end
      check("disp_seen", int'(seen), 1);
   endtask

   task automatic wait_done(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_out) begin seen = 1; break; end
      end
      check("done_seen", int'(seen), 1);
   endtask

   task automatic run_seq(input int a, input int b, input int sel, input int mode,
                          input bit f63, input bit timing, input bit meddle);
      push_exp(a, b, sel, mode, f63);
      len_q.push_back(mode != 0 ? 1 + 4 * (1 + HOLD) : 2 + HOLD);
      done_exp++;
      @(negedge clk);
      num_a_in = 3'(a); num_b_in = 3'(b); sel_op_in = 2'(sel); mode_in = 1'(mode);
      force63 = f63;
      start_in = 1'b1;
      if (timing) begin
         @(posedge clk);
         @(posedge clk); #1 check("busy_edge_n1", int'(busy_out), 0);
         @(posedge clk); #1 check("busy_edge_n2", int'(busy_out), 1);
      end
      wait_busy(10);
      start_in = 1'b0;
      if (meddle) begin
         wait_disp(10);
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_in = ~start_in;
            num_a_in = 3'($urandom); num_b_in = 3'($urandom);
            sel_op_in = 2'($urandom); mode_in = 1'($urandom);
         end
      end
      wait_done(100);
      force63 = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_alu_a"}, int'(alu_a_out), 0);
      check({tag, "_alu_op"}, int'(alu_op_out), 0);
      check({tag, "_busy"}, int'(busy_out), 0);
      check({tag, "_done"}, int'(done_out), 0);
      check({tag, "_disp_on"}, int'(disp_on_out), 0);
      check({tag, "_digit_sel"}, int'(digit_sel_out), 0);
      check({tag, "_digit_val"}, int'(digit_val_out), 0);
   endtask

   initial begin
      #3 check_all_zero("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // manual op with start-to-LOAD latency check
      run_seq(5, 3, 2, 0, 0, 1, 0);
      // auto cycle: 14, 0, 49, 7
      run_seq(7, 7, 0, 1, 0, 0, 0);
      // busy protection during SHOW
      run_seq(6, 2, 1, 1, 0, 0, 1);
      repeat (15) @(negedge clk);
      check("done_count_after_meddle", done_cnt, done_exp);

      // reset in the middle of an auto SHOW
      push_exp(4, 5, 0, 1, 0);
      @(negedge clk);
      num_a_in = 3'd4; num_b_in = 3'd5; mode_in = 1'b1; start_in = 1'b1;
      wait_busy(10);
      start_in = 1'b0;
      wait_disp(10);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      exp_q.delete();
      len_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 check("rst_hold_sel", int'(digit_sel_out), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("no_done_after_rst", done_cnt, done_exp);
      run_seq(4, 5, 0, 1, 0, 0, 0);

      // maximum result on the display
      run_seq(1, 1, 0, 0, 1, 0, 0);

      for (int i = 0; i < 4; i++)
         run_seq(int'($urandom_range(7)), int'($urandom_range(7)),
                 int'($urandom_range(3)), int'($urandom_range(1)), 0, 0, 0);

      repeat (20) @(negedge clk);
      check("done_count", done_cnt, done_exp);
      check("exp_q_empty", exp_q.size(), 0);
      check("len_q_empty", len_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d, expected %0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Operation sequencer and display scheduler for the ALU/decoder datapath. It latches the 3-bit operands and the operation select on a start request and drives them into the ALU. It then captures the ALU result and holds it on the display for a fixed time, either for one operation (manual) or for all four operations in turn (auto). It also time-multiplexes the two decimal result digits onto the shared 7-segment decoder.

## Interface

Parameters:
- HOLD_CYCLES, 1024: clocks each result stays on the display; ≥2.
- SCAN_DIV, 256: clocks per digit in the display scan; ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- num_a_in  in  3  operand A (unsigned).
- num_b_in  in  3  operand B (unsigned).
- sel_op_in  in  2  ALU operation for manual mode.
- mode_in  in  1  0 = manual single op, 1 = auto cycle ops 0..3.
- start_in  in  1  asynchronous start request, level pin.
- alu_res_in  in  6  combinational ALU result for alu_a/alu_b/alu_op (0..63).
- alu_a_out  out  3  latched operand A to the ALU.
- alu_b_out  out  3  latched operand B to the ALU.
- alu_op_out  out  2  current operation to the ALU.
- busy_out  out  1  high in any state other than IDLE.
- done_out  out  1  one-cycle pulse when a sequence completes.
- disp_on_out  out  1  display enable, high only in SHOW.
- digit_sel_out  out  1  0 = ones digit, 1 = tens digit.
- digit_val_out  out  4  BCD value for the selected digit.

## Operation

- Start synchronizer:
  - start_in passes through two flip-flops, then a third register for edge detection.
  - start_pulse = sync2 & ~sync3.
  - Pulses that arrive while busy_out=1 are discarded, not queued.
- FSM states: IDLE, LOAD, EXEC, SHOW.
- IDLE → LOAD on start_pulse.
- LOAD (1 cycle):
  - Latch num_a_in → alu_a_out and num_b_in → alu_b_out.
  - Latch mode_in into mode_r.
  - alu_op_out ← sel_op_in if mode_in=0, else 2'd0.
  - → EXEC.
- EXEC (1 cycle):
  - Capture res_r ← alu_res_in at the end of the cycle.
  - Clear hold_cnt.
  - → SHOW.
- SHOW:
  - hold_cnt increments from 0.
  - At hold_cnt = HOLD_CYCLES-1 the FSM exits:
    - mode_r=0 → IDLE, done_out=1 for 1 cycle.
    - mode_r=1 and alu_op_out<3 → alu_op_out+1, then EXEC.
    - mode_r=1 and alu_op_out=3 → IDLE, done_out=1 for 1 cycle.
- Operands and mode_r are frozen from LOAD until IDLE. Input changes mid-sequence have no effect.
- Digit decode, combinational from res_r:
  - ones = res_r mod 10.
  - tens = res_r / 10, range 0..6.
  - digit_val_out = digit_sel_out ? tens : ones when disp_on_out=1, else 4'd0.
- Scan counter:
  - Free-runs in every state.
  - Counts 0..SCAN_DIV-1, then wraps.
  - digit_sel_out toggles on each wrap.
- Widths: counters are $clog2(parameter) bits. res_r is 6 bits. No saturation is needed because alu_res_in ≤ 63 by contract.

## Timing

- Reset values (asynchronous, all outputs): alu_a/alu_b/alu_op = 0, busy = 0, done = 0, disp_on = 0, digit_sel = 0, digit_val = 0. FSM = IDLE, res_r = 0, both counters = 0, sync flops = 0.
- Reset mid-sequence returns to IDLE immediately. No done pulse is generated.
- start_in first sampled high at edge n:
  - start_pulse is high in the cycle after edge n+1.
  - LOAD is entered at edge n+2.
  - busy_out is high from edge n+2.
- LOAD→EXEC: 1 cycle. EXEC→SHOW: 1 cycle. alu_res_in must be valid in EXEC.
- SHOW lasts exactly HOLD_CYCLES cycles.
- Manual sequence = 2 + HOLD_CYCLES busy cycles.
- Auto sequence = 1 + 4·(1 + HOLD_CYCLES) busy cycles.
- done_out is asserted in the first IDLE cycle; busy_out is already 0 in that cycle.
- If start_in is held high, only one sequence runs. A new sequence needs a low→high transition.
- start_pulse in the same cycle as done_out (IDLE) is accepted.

## Test plan

Bench uses HOLD_CYCLES=8 and SCAN_DIV=4, with an ALU model (op0 = A+B, op1 = |A−B|, op2 = A·B, op3 = A&B).

- Reset:
  - Stimulus: assert rst_n=0 asynchronously between clock edges.
  - Required: all outputs go to 0 immediately. digit_sel holds 0 while in reset.
- Manual op:
  - Stimulus: A=5, B=3, sel_op=2, mode=0; pulse start.
  - Required: LOAD is entered 2 edges after start is first sampled. res_r=15. While disp_on=1, digit_val is 5 when sel=0 and 1 when sel=1. busy is high for 10 cycles, then done pulses once.
- Auto cycle:
  - Stimulus: A=7, B=7, mode=1.
  - Required: alu_op steps 0,1,2,3. Captured results are 14, 0, 49, 7. Each is shown for 8 cycles. busy is high for 37 cycles, followed by a single done.
- Busy protection:
  - Stimulus: toggle start and change A, B, mode and sel_op during SHOW.
  - Required: no restart. alu_a, alu_b and alu_op are unchanged. Exactly one done.
- Reset mid-SHOW:
  - Stimulus: assert rst_n=0 during SHOW of an auto run.
  - Required: IDLE, disp_on=0, no done. A fresh start after reset runs normally from op 0.
- Scan and maximum result:
  - Stimulus: drive alu_res_in=63.
  - Required: digit_sel toggles every 4 cycles. digit_val alternates 3 and 6. digit_val is 0 when disp_on=0.
